// File: rtl/tune_sequencer.sv
// tune_sequencer
//   Plays a note list from a synchronous ROM. Each 8-bit note word holds a
//   pitch code [7:3] and a length code [2:0] (duration 2^L ticks). The pitch
//   code is converted to a half-period divider for the square-wave tone
//   generator. Word 8'h00 ends the tune. P=0 and P=25..31 are rests.
//   Tick timing comes from a prescaler of TICK_DIV clock cycles.
//
// Ports
//   CLK       system clock (single clock domain)
//   RST       synchronous, active-high reset
//   START     one-cycle pulse; begins playback at address 0 when idle
//   STOP      aborts playback from any state; wins over START
//   ROM_ADDR  note word address
//   ROM_DATA  note word, valid the cycle after ROM_ADDR is presented
//   TONE_DIV  half-period reload value for the tone generator
//   TONE_EN   tone generator enable (0 = silent)
//   BUSY      high while a tune is being played
//   DONE      one-cycle pulse on normal completion
//
// Configuration macro
//   TUNE_SEQ_LOOP_EN  when defined, the tune repeats from address 0 on the
//                     end marker (unless it sits at address 0) and on the
//                     address wrap; only STOP or RST ends playback.

module tune_sequencer #(
  parameter int TICK_DIV  = 250000,
  parameter int ADDR_W    = 8,
  parameter int GAP_TICKS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              STOP,
  output logic [ADDR_W-1:0] ROM_ADDR,
  input  logic [7:0]        ROM_DATA,
  output logic [19:0]       TONE_DIV,
  output logic              TONE_EN,
  output logic              BUSY,
  output logic              DONE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  // Notes never exceed 128 ticks, so clamping the gap length to 255 keeps
  // the comparison exact in 8 bits.
  localparam int GAP_CLAMP = (GAP_TICKS > 255) ? 255 : ((GAP_TICKS < 0) ? 0 : GAP_TICKS);
  localparam logic [7:0] GAP_T = 8'(GAP_CLAMP);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_PLAY   = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [7:0]    ticks;    // ticks remaining in the current note, including this one
  logic          gap_en;   // sounded note long enough to carry a silent gap

  // Lower octave half-periods (A3..G#4) at 16 MHz.
  function automatic logic [15:0] base_div(input logic [3:0] idx);
    case (idx)
      4'd0:    base_div = 16'd36364;
      4'd1:    base_div = 16'd34323;
      4'd2:    base_div = 16'd32396;
      4'd3:    base_div = 16'd30578;
      4'd4:    base_div = 16'd28862;
      4'd5:    base_div = 16'd27242;
      4'd6:    base_div = 16'd25713;
      4'd7:    base_div = 16'd24270;
      4'd8:    base_div = 16'd22908;
      4'd9:    base_div = 16'd21622;
      4'd10:   base_div = 16'd20408;
      4'd11:   base_div = 16'd19263;
      default: base_div = 16'd0;
    endcase
  endfunction

  function automatic logic is_rest(input logic [4:0] p);
    is_rest = (p == 5'd0) || (p > 5'd24);
  endfunction

  // Upper octave reuses the lower table at half the period.
  function automatic logic [19:0] pitch_div(input logic [4:0] p);
    logic [15:0] b;
    if (p <= 5'd12) begin
      b = base_div(4'(p - 5'd1));
      pitch_div = {4'd0, b};
    end else begin
      b = base_div(4'(p - 5'd13));
      pitch_div = {5'd0, b[15:1]};
    end
  endfunction

  logic [4:0] pcode;
  logic [2:0] lcode;
  logic [7:0] dur;
  logic       rest;
  logic       tick_end;

  assign pcode    = ROM_DATA[7:3];
  assign lcode    = ROM_DATA[2:0];
  assign dur      = 8'd1 << lcode;
  assign rest     = is_rest(pcode);
  assign tick_end = (presc == PRESC_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      presc    <= '0;
      ticks    <= '0;
      gap_en   <= 1'b0;
      ROM_ADDR <= '0;
      TONE_DIV <= '0;
      TONE_EN  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (STOP && (state != S_IDLE)) begin
        state   <= S_IDLE;
        TONE_EN <= 1'b0;
        BUSY    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (START && !STOP) begin
              state    <= S_FETCH;
              ROM_ADDR <= '0;
              BUSY     <= 1'b1;
            end
          end
          // ROM latency cycle: the word for ROM_ADDR arrives during DECODE.
          S_FETCH: state <= S_DECODE;
          S_DECODE: begin
            if (ROM_DATA == 8'h00) begin
`ifdef TUNE_SEQ_LOOP_EN
              // An end marker at address 0 means an empty tune; finish rather than spin.
              if (ROM_ADDR != '0) begin
                ROM_ADDR <= '0;
                state    <= S_FETCH;
              end else begin
                state <= S_IDLE;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
              end
`else
              state <= S_IDLE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
`endif
            end else begin
              state   <= S_PLAY;
              ticks   <= dur;
              presc   <= '0;
              TONE_EN <= !rest;
              gap_en  <= !rest && (dur > GAP_T);
              if (!rest) TONE_DIV <= pitch_div(pcode);
            end
          end
          S_PLAY: begin
            if (tick_end) begin
              presc <= '0;
              if (ticks == 8'd1) begin
                TONE_EN <= 1'b0;
                if (ROM_ADDR == ADDR_LAST) begin
`ifdef TUNE_SEQ_LOOP_EN
                  ROM_ADDR <= '0;
                  state    <= S_FETCH;
`else
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
                  DONE  <= 1'b1;
`endif
                end else begin
                  ROM_ADDR <= ROM_ADDR + ADDR_W'(1);
                  state    <= S_FETCH;
                end
              end else begin
                ticks <= ticks - 8'd1;
                // Entering the trailing silent ticks of a sounded note.
                if (gap_en && ((ticks - 8'd1) <= GAP_T)) TONE_EN <= 1'b0;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tune_sequencer.sv
module tb_tune_sequencer;

  localparam int TD    = 4;
  localparam int AW    = 4;
  localparam int GAP   = 1;
  localparam int DEPTH = 16;
  localparam int MAXC  = 1024;
`ifdef TUNE_SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          STOP = 1'b0;
  logic [AW-1:0] ROM_ADDR;
  logic [7:0]    ROM_DATA;
  logic [19:0]   TONE_DIV;
  logic          TONE_EN;
  logic          BUSY;
  logic          DONE;

  logic [7:0] rom [DEPTH];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Expected outputs per cycle
  bit e_v    [MAXC];
  bit e_en   [MAXC];
  bit e_busy [MAXC];
  bit e_done [MAXC];
  int e_addr [MAXC];
  int e_div  [MAXC];

  tune_sequencer #(.TICK_DIV(TD), .ADDR_W(AW), .GAP_TICKS(GAP)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .TONE_DIV(TONE_DIV), .TONE_EN(TONE_EN), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    ROM_DATA <= rom[ROM_ADDR];
    cyc      <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, act, want);
    end
  endtask

  always @(negedge CLK) begin
    if (cyc < MAXC && e_v[cyc]) begin
      chk("TONE_EN",  TONE_EN,  e_en[cyc]);
      chk("BUSY",     BUSY,     e_busy[cyc]);
      chk("DONE",     DONE,     e_done[cyc]);
      chk("ROM_ADDR", ROM_ADDR, e_addr[cyc]);
      chk("TONE_DIV", TONE_DIV, e_div[cyc]);
    end
  end

  // ---------------- behavioural model ----------------
  function automatic int tone_of(input int p);
    int tbl [12];
    tbl = '{36364, 34323, 32396, 30578, 28862, 27242,
            25713, 24270, 22908, 21622, 20408, 19263};
    if (p <= 12) return tbl[p-1];
    return tbl[p-13] >> 1;
  endfunction

  task automatic set_c(input int t, input bit en, input bit busy, input bit done,
                       input int addr, input int div);
    if (t >= 0 && t < MAXC) begin
      e_v[t] = 1'b1; e_en[t] = en; e_busy[t] = busy; e_done[t] = done;
      e_addr[t] = addr; e_div[t] = div;
    end
  endtask

  task automatic set_idle(input int from, input int addr, input int div);
    for (int t = from; t < MAXC; t++) set_c(t, 1'b0, 1'b0, 1'b0, addr, div);
  endtask

  // START high during cycle t0: rebuild the expected trace from t0+1 on.
  task automatic plan(input int t0);
    int t, addr, div, w, p, dur;
    bit rest, fin;
    t = t0 + 1; addr = 0; div = e_div[t0]; fin = 1'b0;
    while (!fin && t < MAXC) begin
      set_c(t, 1'b0, 1'b1, 1'b0, addr, div); t++;
      set_c(t, 1'b0, 1'b1, 1'b0, addr, div); t++;
      w = int'(rom[addr]);
      if (w == 0) begin
        if (LOOP && addr != 0) begin
          addr = 0;
          continue;
        end
        set_idle(t, addr, div);
        set_c(t, 1'b0, 1'b0, 1'b1, addr, div);
        fin = 1'b1;
      end else begin
        p = w >> 3;
        dur = 1 << (w & 7);
        rest = (p == 0) || (p > 24);
        if (!rest) div = tone_of(p);
        for (int k = 0; k < dur * TD; k++)
          set_c(t + k, !rest && !(dur > GAP && (dur - k / TD) <= GAP), 1'b1, 1'b0, addr, div);
        t += dur * TD;
        if (addr == DEPTH - 1) begin
          if (LOOP) addr = 0;
          else begin
            set_idle(t, addr, div);
            set_c(t, 1'b0, 1'b0, 1'b1, addr, div);
            fin = 1'b1;
          end
        end else begin
          addr++;
        end
      end
    end
  endtask

  // STOP (or RST) during cycle s: idle from s+1 on.
  task automatic abort(input int s, input bit by_rst);
    if (by_rst) set_idle(s + 1, 0, 0);
    else        set_idle(s + 1, e_addr[s], e_div[s]);
  endtask

  // ---------------- stimulus ----------------
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_start();
    START = 1'b1;
    plan(cyc);
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic do_stop();
    STOP = 1'b1;
    abort(cyc, 1'b0);
    @(posedge CLK); #1;
    STOP = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'h00;
  endtask

  int c, c2;

  initial begin
    clear_rom();
    set_idle(1, 0, 0);
    goto(3);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ROM_ADDR", ROM_ADDR, 0);
    chk("rst_TONE_DIV", TONE_DIV, 0);
    chk("rst_TONE_EN",  TONE_EN, 0);
    chk("rst_BUSY",     BUSY, 0);
    chk("rst_DONE",     DONE, 0);

    // A3 for 4 ticks, then end marker
    clear_rom(); rom[0] = 8'h0A;
    goto(cyc + 1); c = cyc; do_start();
    goto(c + 1);  @(negedge CLK); chk("s1_busy_rise", BUSY, 1);
    goto(c + 3);  @(negedge CLK); chk("s1_first_en", TONE_EN, 1); chk("s1_div", TONE_DIV, 36364);
    goto(c + 14); @(negedge CLK); chk("s1_last_on", TONE_EN, 1);
    goto(c + 15); @(negedge CLK); chk("s1_gap", TONE_EN, 0);
`ifdef TUNE_SEQ_LOOP_EN
    goto(c + 21); @(negedge CLK); chk("s1_loop_addr0", ROM_ADDR, 0); chk("s1_loop_busy", BUSY, 1);
    goto(c + 39); @(negedge CLK); chk("s1_loop_addr1", ROM_ADDR, 1);
    goto(c + 61); @(negedge CLK); chk("s1_loop_addr0_3rd", ROM_ADDR, 0); chk("s1_loop_nodone", DONE, 0);
    goto(c + 70);
`else
    goto(c + 21); @(negedge CLK); chk("s1_done", DONE, 1); chk("s1_busy_fall", BUSY, 0);
    goto(c + 22); @(negedge CLK); chk("s1_done_pulse", DONE, 0);
    goto(c + 25);
`endif
    do_stop();

    // Upper octave A4, one tick: no gap
    clear_rom(); rom[0] = 8'h68;
    goto(cyc + 2); c = cyc; do_start();
    goto(c + 3); @(negedge CLK); chk("s2_div", TONE_DIV, 18182); chk("s2_en", TONE_EN, 1);
    goto(c + 6); @(negedge CLK); chk("s2_no_gap", TONE_EN, 1);
    goto(c + 30); do_stop();

    // Rest of 8 ticks then A3
    clear_rom(); rom[0] = 8'h03; rom[1] = 8'h0A;
    goto(cyc + 2); c = cyc; do_start();
    goto(c + 3);  @(negedge CLK); chk("s3_rest_en", TONE_EN, 0); chk("s3_rest_busy", BUSY, 1);
    chk("s3_rest_div_held", TONE_DIV, 18182);
    goto(c + 34); @(negedge CLK); chk("s3_rest_end", TONE_EN, 0);
    goto(c + 37); @(negedge CLK); chk("s3_note_en", TONE_EN, 1); chk("s3_note_div", TONE_DIV, 36364);
    goto(c + 70); do_stop();

    // High pitch code is a rest
    clear_rom(); rom[0] = 8'hC9;
    goto(cyc + 2); c = cyc; do_start();
    goto(c + 3); @(negedge CLK); chk("s3b_p25_rest", TONE_EN, 0); chk("s3b_div_held", TONE_DIV, 36364);
    goto(c + 20); do_stop();

    // STOP at PLAY cycle 5
    clear_rom(); rom[0] = 8'h0A;
    goto(cyc + 2); c = cyc; do_start();
    goto(c + 7); do_stop();
    goto(c + 8); @(negedge CLK);
    chk("s5_stop_en", TONE_EN, 0); chk("s5_stop_busy", BUSY, 0); chk("s5_stop_done", DONE, 0);
    goto(c + 30);

    // START during PLAY is ignored
    clear_rom(); rom[0] = 8'h08; rom[1] = 8'h0A;
    goto(cyc + 2); c = cyc; do_start();
    goto(c + 12); START = 1'b1; @(posedge CLK); #1; START = 1'b0;
    goto(c + 14); @(negedge CLK); chk("s6_addr_kept", ROM_ADDR, 1); chk("s6_en_kept", TONE_EN, 1);
    goto(c + 40); do_stop();

    // START and STOP together while idle
    goto(cyc + 2); c = cyc;
    START = 1'b1; STOP = 1'b1; abort(c, 1'b0);
    @(posedge CLK); #1; START = 1'b0; STOP = 1'b0;
    goto(c + 3); @(negedge CLK); chk("s7_busy", BUSY, 0); chk("s7_en", TONE_EN, 0);
    goto(c + 5);

    // RST during PLAY, then replay
    clear_rom(); rom[0] = 8'h0A;
    c = cyc; do_start();
    goto(c + 8); RST = 1'b1; abort(c + 8, 1'b1);
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK);
    chk("s8_rst_div", TONE_DIV, 0); chk("s8_rst_busy", BUSY, 0);
    chk("s8_rst_addr", ROM_ADDR, 0); chk("s8_rst_en", TONE_EN, 0);
    c2 = cyc + 2; goto(c2); do_start();
    goto(c2 + 3); @(negedge CLK); chk("s8_replay_div", TONE_DIV, 36364); chk("s8_replay_addr", ROM_ADDR, 0);
    goto(c2 + 30); do_stop();

    // Full ROM: last address ends (or wraps) without a marker
    for (int i = 0; i < DEPTH; i++) rom[i] = {5'(i + 1), 3'b000};
    goto(cyc + 2); c = cyc; do_start();
    goto(c + 94); @(negedge CLK); chk("s9_p16_div", TONE_DIV, 15289);
`ifdef TUNE_SEQ_LOOP_EN
    goto(c + 97); @(negedge CLK); chk("s9_wrap_addr", ROM_ADDR, 0); chk("s9_wrap_busy", BUSY, 1);
`else
    goto(c + 97); @(negedge CLK); chk("s9_last_done", DONE, 1); chk("s9_last_addr", ROM_ADDR, 15);
`endif
    goto(c + 110); do_stop();

    // Empty ROM finishes in both builds
    clear_rom();
    goto(cyc + 2); c = cyc; do_start();
    goto(c + 3); @(negedge CLK); chk("s10_empty_done", DONE, 1); chk("s10_empty_busy", BUSY, 0);
    goto(c + 6);

    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
